hazard_arbiter_n: RTL and testbench
===================================

Name: hazard_arbiter_n

Overview:
- Parametrised successor to the fixed five-stage hazard controller.
- Takes per-stage stall requests and per-stage PC-redirect requests from an N-stage pipeline.
- Resolves them into PC/pipeline-register stall and flush controls and a single PC load.
- Also keeps per-stage hazard statistics counters, readable through a select/read port, plus a front-end stall watchdog for simulation-free performance and deadlock diagnosis.

Parameters:
- NUM_STAGES, 5: pipeline stages; stage 0 = IF (youngest), NUM_STAGES-1 = MEM (oldest before WB).
- DELAY_SLOTS, 1: number of younger instructions a redirect does not kill.
- ADDR_W, 32: PC width.
- CNT_W, 32: statistics counter width; counters saturate.
- WDOG_CYCLES, 1024: consecutive stage-0 stall cycles before the watchdog fires; 0 disables it.
- SEL_W, $clog2(3*NUM_STAGES): counter select width.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset
- stall_req  in  NUM_STAGES  bit i: stage i cannot complete this cycle
- redirect_valid  in  NUM_STAGES  bit i: stage i requests PC redirect
- redirect_pc  in  NUM_STAGES*ADDR_W  slice i = target for stage i
- pc_stall  out  1  hold PC register
- reg_stall  out  NUM_STAGES  bit k: hold register feeding stage k+1 (k=N-1 feeds WB)
- reg_flush  out  NUM_STAGES  bit k: load bubble into register k
- load_pc_we  out  1  PC overload enable
- load_pc_new  out  ADDR_W  overload target
- cnt_sel  in  SEL_W  counter index
- cnt_rdata  out  CNT_W  registered counter value
- cnt_clr  in  1  synchronous clear of all counters and watchdog
- wdog_fire  out  1  one-cycle pulse at watchdog expiry
- wdog_tripped  out  1  sticky watchdog flag

Interface: one clock, clk. Reset rst_n is asynchronous, active-low.

Behaviour:
- Control outputs are combinational in the current-cycle inputs. No state affects them.
- Downstream stall, where D[i] means a stage older than i stalls: D[N-1]=0; D[i]=stall_req[i+1] | D[i+1].
- Effective stall: S[i]=stall_req[i] | D[i].
- Redirect acceptance:
  - A redirect from stage j is accepted only if D[j]=0.
  - If several are accepted, the highest j wins.
  - load_pc_we = any accepted redirect; load_pc_new = redirect_pc slice of the winner, else 0.
- Redirect from winner j:
  - Sets reg_flush[k]=1 for every k with k < j-DELAY_SLOTS.
  - Forces pc_stall=0, overriding any stage-0 stall_req.
  - Does not override a stall from any stage at or beyond j-DELAY_SLOTS.
- pc_stall = S[0], except as overridden above.
- reg_stall[k] = D[k].
- reg_flush[k]: also set when stall_req[k]=1 & D[k]=0 (own stall inserts a bubble downstream).
  - Stall takes priority: reg_flush[k] is cleared when reg_stall[k]=1.
- Counters, one per index, clearing to 0 and saturating at all-ones:
  - idx 2i: cycles with stall_req[i]=1.
  - idx 2i+1: stall episodes, i.e. rising edges of stall_req[i] versus the registered previous value.
  - idx 2N+j: accepted redirects from stage j.
- Counter clear and read:
  - cnt_clr has priority over increment in the same cycle.
  - Edge-history registers are not cleared by cnt_clr, so a continuing stall is not recounted.
- cnt_rdata = counter[cnt_sel] registered: value appears 1 cycle after cnt_sel. An out-of-range sel reads 0.
- Watchdog:
  - Counter increments while pc_stall=1 and resets to 0 when pc_stall=0.
  - When the count reaches WDOG_CYCLES-1 while pc_stall=1, the next cycle asserts wdog_fire for 1 cycle and sets wdog_tripped.
  - The counter then holds; it refires only after pc_stall deasserts and a new run reaches the limit.
  - cnt_clr clears the counter and wdog_tripped.
- Reset, asynchronous, including mid-operation: all counters, edge history, watchdog count, cnt_rdata, wdog_fire and wdog_tripped go to 0.

Test Plan (NUM_STAGES=5, DELAY_SLOTS=1, WDOG_CYCLES=16):
- stall_req=00001 -> pc_stall=1, reg_stall=00000, reg_flush=00001, load_pc_we=0.
- stall_req=10000 -> pc_stall=1, reg_stall=01111, reg_flush=10000.
- stall_req=00001 with redirect_valid=00100, pc 0x0000_0400 -> pc_stall=0, load_pc_we=1, load_pc_new=0x400, reg_flush=00001.
- redirect_valid=00110 (stage1 0x100, stage2 0x200) -> load_pc_new=0x200. Same with stall_req=01000 -> load_pc_we=0, pc_stall=1.
- stall_req[4] high 3 cycles, low 1, high 2, then cnt_sel=8 -> cnt_rdata=5 one cycle later; cnt_sel=9 -> 2. cnt_clr -> both read 0. rst_n pulsed low mid-count -> 0 immediately.
- stall_req[0] held 20 cycles -> wdog_fire high exactly in cycle 17 only, wdog_tripped stays 1 until cnt_clr.

Source files
------------

// File: rtl/hazard_arbiter_n.sv
// hazard_arbiter_n: N-stage stall/redirect resolver with saturating hazard counters and a front-end stall watchdog.
module hazard_arbiter_n #(
  parameter int NUM_STAGES  = 5,
  parameter int DELAY_SLOTS = 1,
  parameter int ADDR_W      = 32,
  parameter int CNT_W       = 32,
  parameter int WDOG_CYCLES = 1024,
  parameter int SEL_W       = $clog2(3*NUM_STAGES)
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_STAGES-1:0]        stall_req,
  input  logic [NUM_STAGES-1:0]        redirect_valid,
  input  logic [NUM_STAGES*ADDR_W-1:0] redirect_pc,
  output logic                         pc_stall,
  output logic [NUM_STAGES-1:0]        reg_stall,
  output logic [NUM_STAGES-1:0]        reg_flush,
  output logic                         load_pc_we,
  output logic [ADDR_W-1:0]            load_pc_new,
  input  logic [SEL_W-1:0]             cnt_sel,
  output logic [CNT_W-1:0]             cnt_rdata,
  input  logic                         cnt_clr,
  output logic                         wdog_fire,
  output logic                         wdog_tripped
);
  localparam int N  = NUM_STAGES;
  localparam int NC = 3*N;
  localparam int WW = (WDOG_CYCLES > 1) ? $clog2(WDOG_CYCLES) : 1;
  localparam logic [WW-1:0] WLIM = WW'((WDOG_CYCLES > 0) ? WDOG_CYCLES-1 : 0);
  logic [N-1:0] d, acc, rf;
  always_comb begin
    d = '0;
    for (int i = 0; i < N; i++) d[i] = |(stall_req >> (i+1));
  end
  assign acc = redirect_valid & ~d;
  // ascending scan so the oldest accepted redirect overwrites younger ones
  always_comb begin
    rf = '0;
    load_pc_new = '0;
    for (int j = 0; j < N; j++) begin
      if (acc[j]) begin
        load_pc_new = redirect_pc[j*ADDR_W +: ADDR_W];
        for (int k = 0; k < N; k++) rf[k] = (k + DELAY_SLOTS < j);
      end
    end
  end
  assign load_pc_we = |acc;
  assign pc_stall   = (stall_req[0] | d[0]) & ~load_pc_we;
  assign reg_stall  = d;
  assign reg_flush  = (stall_req | rf) & ~d;
  logic [CNT_W-1:0] cnt [NC];
  logic [NC-1:0]    inc;
  logic [N-1:0]     prev;
  always_comb begin
    inc = '0;
    for (int i = 0; i < N; i++) begin
      inc[2*i]   = stall_req[i];
      inc[2*i+1] = stall_req[i] & ~prev[i];
      inc[2*N+i] = acc[i];
    end
  end
  // edge history survives cnt_clr so an ongoing stall is not recounted as a new episode
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NC; i++) cnt[i] <= '0;
      prev <= '0;
      cnt_rdata <= '0;
    end else begin
      prev <= stall_req;
      cnt_rdata <= (32'(cnt_sel) < NC) ? cnt[cnt_sel] : '0;
      for (int i = 0; i < NC; i++)
        if (cnt_clr) cnt[i] <= '0;
        else if (inc[i] && !(&cnt[i])) cnt[i] <= cnt[i] + 1'b1;
    end
  end
  logic [WW-1:0] wcnt;
  logic          wdone, whit;
  assign whit = (WDOG_CYCLES != 0) && pc_stall && (wcnt == WLIM) && !wdone;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wcnt <= '0;
      wdone <= 1'b0;
      wdog_fire <= 1'b0;
      wdog_tripped <= 1'b0;
    end else if (cnt_clr) begin
      wcnt <= '0;
      wdone <= 1'b0;
      wdog_fire <= 1'b0;
      wdog_tripped <= 1'b0;
    end else begin
      wdog_fire <= whit;
      if (whit) begin
        wdone <= 1'b1;
        wdog_tripped <= 1'b1;
      end
      if (!pc_stall) begin
        wcnt <= '0;
        wdone <= 1'b0;
      end else if (wcnt != WLIM) wcnt <= wcnt + 1'b1;
    end
  end
endmodule

// File: tb/tb_hazard_arbiter_n.sv
// tb_hazard_arbiter_n: random + directed checks of hazard_arbiter_n against a rule-level reference model.
module tb_hazard_arbiter_n;
  localparam int N = 5, AW = 32, CW = 8, W = 16, SW = 4;
  logic clk = 0, rst_n = 0, clr = 0;
  logic [N-1:0] sr = 0, rv = 0;
  logic [N*AW-1:0] rpc = 0;
  logic [SW-1:0] sel = 0;
  logic pcs, we, fire, trip;
  logic [N-1:0] rst_o, rfl;
  logic [AW-1:0] lpn;
  logic [CW-1:0] rd;
  int tests = 0, fails = 0;
  int mcnt [3*N];
  logic [N-1:0] mprev;
  int mrd, run;
  bit mfire, mtrip;
  hazard_arbiter_n #(.NUM_STAGES(N), .DELAY_SLOTS(1), .ADDR_W(AW), .CNT_W(CW), .WDOG_CYCLES(W), .SEL_W(SW)) dut (
    .clk(clk), .rst_n(rst_n), .stall_req(sr), .redirect_valid(rv), .redirect_pc(rpc),
    .pc_stall(pcs), .reg_stall(rst_o), .reg_flush(rfl), .load_pc_we(we), .load_pc_new(lpn),
    .cnt_sel(sel), .cnt_rdata(rd), .cnt_clr(clr), .wdog_fire(fire), .wdog_tripped(trip));
  always #5 clk = ~clk;
  task automatic chk(input string nm, input logic [63:0] a, input logic [63:0] e);
    tests++;
    if (a !== e) begin
      fails++;
      $display("FAIL %s actual=%0h required=%0h", nm, a, e);
    end
  endtask
  // outputs recomputed from the stall/redirect rules on the current inputs
  task automatic model_comb(output bit e_pcs, output bit [N-1:0] e_rs, output bit [N-1:0] e_fl,
                            output bit e_we, output bit [AW-1:0] e_new, output bit [N-1:0] e_acc);
    int win = -1;
    e_rs = 0; e_fl = 0; e_acc = 0;
    for (int i = 0; i < N; i++)
      for (int j = i+1; j < N; j++) if (sr[j]) e_rs[i] = 1;
    for (int j = 0; j < N; j++) if (rv[j] && !e_rs[j]) begin e_acc[j] = 1; win = j; end
    e_we  = (win >= 0);
    e_new = (win >= 0) ? rpc[win*AW +: AW] : 0;
    e_pcs = (sr[0] || e_rs[0]) && (win < 0);
    for (int k = 0; k < N; k++) e_fl[k] = !e_rs[k] && (sr[k] || (win >= 0 && k + 1 < win));
  endtask
  task automatic model_reset();
    for (int i = 0; i < 3*N; i++) mcnt[i] = 0;
    mprev = 0; mrd = 0; run = 0; mfire = 0; mtrip = 0;
  endtask
  task automatic cycle();
    bit e_pcs, e_we;
    bit [N-1:0] e_rs, e_fl, e_acc;
    bit [AW-1:0] e_new;
    @(negedge clk);
    model_comb(e_pcs, e_rs, e_fl, e_we, e_new, e_acc);
    chk("pc_stall", pcs, e_pcs);
    chk("reg_stall", rst_o, e_rs);
    chk("reg_flush", rfl, e_fl);
    chk("load_pc_we", we, e_we);
    chk("load_pc_new", lpn, e_new);
    chk("cnt_rdata", rd, mrd);
    chk("wdog_fire", fire, mfire);
    chk("wdog_tripped", trip, mtrip);
    @(posedge clk);
    if (rst_n) begin
      mrd = (sel < 3*N) ? mcnt[sel] : 0;
      if (clr) begin
        run = 0; mfire = 0; mtrip = 0;
        for (int i = 0; i < 3*N; i++) mcnt[i] = 0;
      end else begin
        run = e_pcs ? run + 1 : 0;
        mfire = (run == W);
        mtrip = mtrip || mfire;
        for (int i = 0; i < N; i++) begin
          if (sr[i]) mcnt[2*i] = (mcnt[2*i] < 255) ? mcnt[2*i] + 1 : 255;
          if (sr[i] && !mprev[i]) mcnt[2*i+1] = (mcnt[2*i+1] < 255) ? mcnt[2*i+1] + 1 : 255;
          if (e_acc[i]) mcnt[2*N+i] = (mcnt[2*N+i] < 255) ? mcnt[2*N+i] + 1 : 255;
        end
      end
      mprev = sr;
    end
    #1;
  endtask
  task automatic drive(input logic [N-1:0] s, input logic [N-1:0] r);
    sr = s; rv = r; #1;
  endtask
  task automatic clear();
    clr = 1; cycle(); clr = 0;
  endtask
  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rdata", rd, 0);
    chk("reset_fire", fire, 0);
    chk("reset_trip", trip, 0);
    rst_n = 1;
    drive(5'b00001, 0);
    chk("t1_pcs", pcs, 1); chk("t1_rs", rst_o, 5'b00000); chk("t1_fl", rfl, 5'b00001); chk("t1_we", we, 0);
    cycle();
    drive(5'b10000, 0);
    chk("t2_pcs", pcs, 1); chk("t2_rs", rst_o, 5'b01111); chk("t2_fl", rfl, 5'b10000);
    cycle();
    rpc[2*AW +: AW] = 32'h400;
    drive(5'b00001, 5'b00100);
    chk("t3_pcs", pcs, 0); chk("t3_we", we, 1); chk("t3_new", lpn, 32'h400); chk("t3_fl", rfl, 5'b00001);
    cycle();
    rpc[AW +: AW] = 32'h100; rpc[2*AW +: AW] = 32'h200;
    drive(0, 5'b00110);
    chk("t4_new", lpn, 32'h200); chk("t4_we", we, 1);
    cycle();
    drive(5'b01000, 5'b00110);
    chk("t4s_we", we, 0); chk("t4s_pcs", pcs, 1);
    cycle();
    drive(0, 0);
    clear();
    drive(5'b10000, 0); repeat (3) cycle();
    drive(0, 0); cycle();
    drive(5'b10000, 0); repeat (2) cycle();
    drive(0, 0);
    sel = 8; cycle(); chk("cnt8", rd, 5);
    sel = 9; cycle(); chk("cnt9", rd, 2);
    clear();
    sel = 8; cycle(); chk("cnt8_clr", rd, 0);
    sel = 9; cycle(); chk("cnt9_clr", rd, 0);
    drive(5'b10000, 0); sel = 8; repeat (3) cycle();
    chk("cnt8_pre_rst", rd, 2);
    rst_n = 0; #1;
    chk("mid_rst_rdata", rd, 0);
    model_reset();
    @(posedge clk); #1; rst_n = 1;
    drive(0, 0); clear();
    drive(5'b00001, 0);
    for (int c = 1; c <= 20; c++) begin
      chk("wdog_fire_run", fire, c == 17);
      chk("wdog_trip_run", trip, c >= 17);
      cycle();
    end
    drive(0, 0); repeat (3) cycle();
    chk("wdog_trip_hold", trip, 1);
    clear(); #1;
    chk("wdog_trip_clr", trip, 0);
    drive(5'b00010, 0); repeat (260) cycle();
    drive(0, 0);
    sel = 2; cycle(); chk("cnt2_sat", rd, 255);
    sel = 3; cycle(); chk("cnt3_one", rd, 1);
    sel = 15; cycle(); chk("sel_oob", rd, 0);
    for (int n = 0; n < 1500; n++) begin
      logic [N-1:0] s, r;
      for (int i = 0; i < N; i++) begin
        s[i] = ($urandom_range(0, 3) == 0);
        r[i] = ($urandom_range(0, 2) == 0);
        rpc[i*AW +: AW] = $urandom;
      end
      if (n % 200 < 40) s[0] = 1'b1;
      sel = SW'($urandom_range(0, 15));
      clr = ($urandom_range(0, 60) == 0);
      drive(s, r);
      cycle();
    end
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
